// File: rtl/j1_io_pkg.sv
// Shared definitions for the j1 UART I/O peripheral: register offsets,
// status bit positions and the TX/RX state encodings.
package j1_io_pkg;

  localparam logic [15:0] OFS_DATA   = 16'd0;
  localparam logic [15:0] OFS_STATUS = 16'd2;

  localparam int ST_TX_BUSY    = 0;
  localparam int ST_RX_VALID   = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_RX_FRERR   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // RX_WAIT holds after a bad stop bit until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_t;

  function automatic logic [15:0] status_word(input logic frerr, input logic overrun,
                                              input logic valid, input logic busy);
    logic [15:0] w;
    w                = 16'h0000;
    w[ST_TX_BUSY]    = busy;
    w[ST_RX_VALID]   = valid;
    w[ST_RX_OVERRUN] = overrun;
    w[ST_RX_FRERR]   = frerr;
    return w;
  endfunction

endpackage

// File: rtl/j1_uart_bit_timer.sv
// Bit-period down-counter: full or half-period load, auto-reload on tick
// while enabled, so one load paces a whole run of bit periods.
module j1_uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic half_load,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_VAL = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_VAL = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
  localparam logic [W-1:0] ONE_VAL  = W'(1);

  logic [W-1:0] cnt_r;

  // Counter register: loads take priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO_VAL;
    end else if (load) begin
      cnt_r <= FULL_VAL;
    end else if (half_load) begin
      cnt_r <= HALF_VAL;
    end else if (en) begin
      if (cnt_r == ZERO_VAL) begin
        cnt_r <= FULL_VAL;
      end else begin
        cnt_r <= cnt_r - ONE_VAL;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = en & (cnt_r == ZERO_VAL);

endmodule

// File: rtl/j1_uart_io.sv
// 8N1 UART peripheral on the j1 I/O bus: DATA register for TX/RX bytes and
// a STATUS register with busy/valid/overrun/frame-error flags.
module j1_uart_io
  import j1_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h5000,
  parameter int          CLKS_PER_BIT = 434
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        sel_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i
);

  localparam logic [15:0] ADDR_DATA   = BASE_ADDR + OFS_DATA;
  localparam logic [15:0] ADDR_STATUS = BASE_ADDR + OFS_STATUS;

  logic data_hit_s, status_hit_s, rd_data_s, wr_data_s, wr_status_s;
  logic unused_s;

  tx_state_t  tx_state_r, tx_state_nx_s;
  logic [7:0] tx_shift_r, tx_shift_nx_s;
  logic [2:0] tx_idx_r, tx_idx_nx_s;
  logic       tx_line_r, tx_line_nx_s;
  logic       tx_load_s, tx_en_s, tx_tick_s, tx_busy_s;

  rx_state_t  rx_state_r, rx_state_nx_s;
  logic [7:0] rx_shift_r, rx_shift_nx_s;
  logic [2:0] rx_idx_r, rx_idx_nx_s;
  logic       rx_meta_r, rx_sync_r;
  logic       rx_half_load_s, rx_en_s, rx_tick_s;
  logic       byte_done_s, frame_bad_s;

  logic [7:0] rx_data_r;
  logic       rx_valid_r, rx_overrun_r, rx_frerr_r;

  assign data_hit_s   = (io_addr == ADDR_DATA);
  assign status_hit_s = (io_addr == ADDR_STATUS);
  assign sel_o        = data_hit_s | status_hit_s;
  assign rd_data_s    = io_rd & data_hit_s;
  assign wr_data_s    = io_wr & data_hit_s;
  assign wr_status_s  = io_wr & status_hit_s;
  assign unused_s     = &{1'b0, io_dout[15:8]};

  assign tx_busy_s = (tx_state_r != TX_IDLE);
  assign uart_tx_o = tx_line_r;

  // Read mux: combinational because the CPU consumes io_din in the io_rd cycle.
  always_comb begin
    io_din = 16'h0000;
    if (data_hit_s) begin
      io_din = {8'h00, rx_data_r};
    end else if (status_hit_s) begin
      io_din = status_word(rx_frerr_r, rx_overrun_r, rx_valid_r, tx_busy_s);
    end else begin
      io_din = 16'h0000;
    end
  end

  j1_uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk       (sys_clk_i),
    .rst       (sys_rst_i),
    .en        (tx_en_s),
    .load      (tx_load_s),
    .half_load (1'b0),
    .tick      (tx_tick_s)
  );

  j1_uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk       (sys_clk_i),
    .rst       (sys_rst_i),
    .en        (rx_en_s),
    .load      (1'b0),
    .half_load (rx_half_load_s),
    .tick      (rx_tick_s)
  );

  // TX state, shifter and registered serial line.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_state_r <= TX_IDLE;
      tx_shift_r <= 8'h00;
      tx_idx_r   <= 3'd0;
      tx_line_r  <= 1'b1;
    end else begin
      tx_state_r <= tx_state_nx_s;
      tx_shift_r <= tx_shift_nx_s;
      tx_idx_r   <= tx_idx_nx_s;
      tx_line_r  <= tx_line_nx_s;
    end
  end

  // TX next-state: the line value for the next bit is chosen at each tick.
  always_comb begin
    tx_state_nx_s = tx_state_r;
    tx_shift_nx_s = tx_shift_r;
    tx_idx_nx_s   = tx_idx_r;
    tx_line_nx_s  = tx_line_r;
    tx_load_s     = 1'b0;
    tx_en_s       = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        tx_line_nx_s = 1'b1;
        if (wr_data_s) begin
          tx_state_nx_s = TX_START;
          tx_shift_nx_s = io_dout[7:0];
          tx_idx_nx_s   = 3'd0;
          tx_line_nx_s  = 1'b0;
          tx_load_s     = 1'b1;
        end else begin
          tx_state_nx_s = TX_IDLE;
        end
      end
      TX_START: begin
        tx_en_s = 1'b1;
        if (tx_tick_s) begin
          tx_state_nx_s = TX_DATA;
          tx_line_nx_s  = tx_shift_r[0];
        end else begin
          tx_state_nx_s = TX_START;
        end
      end
      TX_DATA: begin
        tx_en_s = 1'b1;
        if (tx_tick_s && (tx_idx_r == 3'd7)) begin
          tx_state_nx_s = TX_STOP;
          tx_line_nx_s  = 1'b1;
        end else if (tx_tick_s) begin
          tx_shift_nx_s = {1'b0, tx_shift_r[7:1]};
          tx_line_nx_s  = tx_shift_r[1];
          tx_idx_nx_s   = tx_idx_r + 3'd1;
        end else begin
          tx_state_nx_s = TX_DATA;
        end
      end
      TX_STOP: begin
        tx_en_s = 1'b1;
        if (tx_tick_s) begin
          tx_state_nx_s = TX_IDLE;
        end else begin
          tx_state_nx_s = TX_STOP;
        end
      end
      default: begin
        tx_state_nx_s = TX_IDLE;
        tx_line_nx_s  = 1'b1;
      end
    endcase
  end

  // RX synchronizer and receive state registers.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_meta_r  <= 1'b1;
      rx_sync_r  <= 1'b1;
      rx_state_r <= RX_IDLE;
      rx_shift_r <= 8'h00;
      rx_idx_r   <= 3'd0;
    end else begin
      rx_meta_r  <= uart_rx_i;
      rx_sync_r  <= rx_meta_r;
      rx_state_r <= rx_state_nx_s;
      rx_shift_r <= rx_shift_nx_s;
      rx_idx_r   <= rx_idx_nx_s;
    end
  end

  // RX next-state: half-period load centres every later sample mid-bit.
  always_comb begin
    rx_state_nx_s  = rx_state_r;
    rx_shift_nx_s  = rx_shift_r;
    rx_idx_nx_s    = rx_idx_r;
    rx_half_load_s = 1'b0;
    rx_en_s        = 1'b0;
    byte_done_s    = 1'b0;
    frame_bad_s    = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        if (!rx_sync_r) begin
          rx_state_nx_s  = RX_START;
          rx_half_load_s = 1'b1;
        end else begin
          rx_state_nx_s = RX_IDLE;
        end
      end
      RX_START: begin
        rx_en_s = 1'b1;
        if (rx_tick_s && rx_sync_r) begin
          rx_state_nx_s = RX_IDLE;
        end else if (rx_tick_s) begin
          rx_state_nx_s = RX_DATA;
          rx_idx_nx_s   = 3'd0;
        end else begin
          rx_state_nx_s = RX_START;
        end
      end
      RX_DATA: begin
        rx_en_s = 1'b1;
        if (rx_tick_s) begin
          rx_shift_nx_s = {rx_sync_r, rx_shift_r[7:1]};
          if (rx_idx_r == 3'd7) begin
            rx_state_nx_s = RX_STOP;
          end else begin
            rx_idx_nx_s = rx_idx_r + 3'd1;
          end
        end else begin
          rx_state_nx_s = RX_DATA;
        end
      end
      RX_STOP: begin
        rx_en_s = 1'b1;
        if (rx_tick_s && rx_sync_r) begin
          byte_done_s   = 1'b1;
          rx_state_nx_s = RX_IDLE;
        end else if (rx_tick_s) begin
          frame_bad_s   = 1'b1;
          rx_state_nx_s = RX_WAIT;
        end else begin
          rx_state_nx_s = RX_STOP;
        end
      end
      RX_WAIT: begin
        if (rx_sync_r) begin
          rx_state_nx_s = RX_IDLE;
        end else begin
          rx_state_nx_s = RX_WAIT;
        end
      end
      default: begin
        rx_state_nx_s = RX_IDLE;
      end
    endcase
  end

  // Receive status: a completing byte beats a same-cycle DATA read, and
  // sticky error sets beat same-cycle clear writes.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      rx_overrun_r <= 1'b0;
      rx_frerr_r   <= 1'b0;
    end else begin
      if (byte_done_s && (!rx_valid_r || rd_data_s)) begin
        rx_data_r  <= rx_shift_r;
        rx_valid_r <= 1'b1;
      end else if (rd_data_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end

      if (byte_done_s && rx_valid_r && !rd_data_s) begin
        rx_overrun_r <= 1'b1;
      end else if (wr_status_s && io_dout[ST_RX_OVERRUN]) begin
        rx_overrun_r <= 1'b0;
      end else begin
        rx_overrun_r <= rx_overrun_r;
      end

      if (frame_bad_s) begin
        rx_frerr_r <= 1'b1;
      end else if (wr_status_s && io_dout[ST_RX_FRERR]) begin
        rx_frerr_r <= 1'b0;
      end else begin
        rx_frerr_r <= rx_frerr_r;
      end
    end
  end

endmodule

// File: tb/tb_j1_uart_io.sv
// Directed bench for j1_uart_io: bus decode, TX framing, RX status flags,
// coincident read/complete and mid-frame reset.
module tb_j1_uart_io;

  localparam int          CLKS      = 434;
  localparam int          HALF      = CLKS / 2;
  localparam logic [15:0] ADDR_DATA = 16'h5000;
  localparam logic [15:0] ADDR_ST   = 16'h5002;

  logic        clk;
  logic        sys_rst_i;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        sel_o;
  logic        uart_tx_o;
  logic        uart_rx_i;

  int checks = 0;
  int errors = 0;

  j1_uart_io #(.BASE_ADDR(16'h5000), .CLKS_PER_BIT(CLKS)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (sys_rst_i),
    .io_rd     (io_rd),
    .io_wr     (io_wr),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_din    (io_din),
    .sel_o     (sel_o),
    .uart_tx_o (uart_tx_o),
    .uart_rx_i (uart_rx_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Combinational read with the strobe dropped before the next edge.
  task automatic peek(input logic [15:0] addr, output logic [15:0] d, output logic s);
    io_addr = addr;
    io_rd   = 1'b1;
    #1;
    d       = io_din;
    s       = sel_o;
    io_rd   = 1'b0;
    io_addr = 16'h0000;
  endtask

  task automatic chk_reg(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    logic [15:0] d;
    logic        s;
    peek(addr, d, s);
    check(tag, d, exp);
  endtask

  task automatic bus_read(input logic [15:0] addr, output logic [15:0] d);
    io_addr = addr;
    io_rd   = 1'b1;
    #1;
    d = io_din;
    adv(1);
    io_rd   = 1'b0;
    io_addr = 16'h0000;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    io_addr = addr;
    io_dout = data;
    io_wr   = 1'b1;
    adv(1);
    io_wr   = 1'b0;
    io_addr = 16'h0000;
  endtask

  // Drive one frame; done_at is the first cycle STATUS differs from its
  // value at frame start, rd_at is the cycle a DATA read strobe is raised.
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int rd_at,
                          output int done_at);
    logic [9:0]  bits;
    logic [15:0] st0;
    logic [15:0] st;
    logic        s;
    bits    = {stop, b, 1'b0};
    done_at = -1;
    peek(ADDR_ST, st0, s);
    for (int p = 0; p < 10 * CLKS; p++) begin
      uart_rx_i = bits[p / CLKS];
      peek(ADDR_ST, st, s);
      if (done_at < 0 && st !== st0) done_at = p;
      if (p == rd_at) begin
        io_addr = ADDR_DATA;
        io_rd   = 1'b1;
      end
      @(posedge clk);
      #1;
      io_rd = 1'b0;
    end
    uart_rx_i = 1'b1;
  endtask

  logic [15:0] rd;
  logic        sl;
  logic [9:0]  tx_exp;
  int          cal;
  int          d;

  initial begin
    sys_rst_i = 1'b1;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    io_addr   = 16'h0000;
    io_dout   = 16'h0000;
    uart_rx_i = 1'b1;
    adv(3);
    sys_rst_i = 1'b0;
    adv(1);

    // Reset state and address decode
    peek(ADDR_ST, rd, sl);
    check("rst_status", rd, 16'h0000);
    check("rst_sel_status", {15'd0, sl}, 16'h0001);
    check("rst_tx_line", {15'd0, uart_tx_o}, 16'h0001);
    peek(ADDR_DATA, rd, sl);
    check("rst_data", rd, 16'h0000);
    check("rst_sel_data", {15'd0, sl}, 16'h0001);
    peek(16'h4000, rd, sl);
    check("miss_din", rd, 16'h0000);
    check("miss_sel", {15'd0, sl}, 16'h0000);
    peek(16'h5004, rd, sl);
    check("miss_sel_5004", {15'd0, sl}, 16'h0000);

    // TX frame of 8'hA5; a second write one cycle later must be dropped
    tx_exp = 10'b1_1010_0101_0;
    bus_write(ADDR_DATA, 16'h00A5);
    check("tx_start_edge", {15'd0, uart_tx_o}, 16'h0000);
    chk_reg("tx_busy_set", ADDR_ST, 16'h0001);
    bus_write(ADDR_DATA, 16'h00FF);
    adv(HALF - 1);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("tx_bit%0d", k), {15'd0, uart_tx_o}, {15'd0, tx_exp[k]});
      if (k < 9) adv(CLKS);
    end
    adv(HALF - 1);
    chk_reg("tx_busy_last_cycle", ADDR_ST, 16'h0001);
    adv(1);
    chk_reg("tx_busy_clear", ADDR_ST, 16'h0000);
    adv(CLKS);
    check("tx_idle_after_frame", {15'd0, uart_tx_o}, 16'h0001);

    // RX 8'h3C, also measures when a byte lands relative to frame start
    rx_frame(8'h3C, 1'b1, -1, cal);
    check("rx_cal_window", {15'd0, (cal >= 9 * CLKS) && (cal < 10 * CLKS)}, 16'h0001);
    chk_reg("rx_3c_status", ADDR_ST, 16'h0002);
    bus_read(ADDR_DATA, rd);
    check("rx_3c_data", rd, 16'h003C);
    chk_reg("rx_3c_cleared", ADDR_ST, 16'h0000);

    // Overrun: second byte dropped, first kept
    rx_frame(8'h11, 1'b1, -1, d);
    rx_frame(8'h22, 1'b1, -1, d);
    chk_reg("ovr_data", ADDR_DATA, 16'h0011);
    chk_reg("ovr_status", ADDR_ST, 16'h0006);
    bus_write(ADDR_ST, 16'h0004);
    chk_reg("ovr_cleared", ADDR_ST, 16'h0002);

    // Bad stop bit, then a short glitch
    rx_frame(8'h55, 1'b0, -1, d);
    adv(CLKS);
    chk_reg("frerr_status", ADDR_ST, 16'h000A);
    chk_reg("frerr_data_kept", ADDR_DATA, 16'h0011);
    uart_rx_i = 1'b0;
    adv(100);
    uart_rx_i = 1'b1;
    adv(CLKS);
    chk_reg("glitch_status", ADDR_ST, 16'h000A);
    bus_write(ADDR_ST, 16'h0008);
    chk_reg("frerr_cleared", ADDR_ST, 16'h0002);

    // DATA read on the exact edge 8'h7E completes
    rx_frame(8'h7E, 1'b1, cal - 1, d);
    chk_reg("coinc_status", ADDR_ST, 16'h0002);
    chk_reg("coinc_data", ADDR_DATA, 16'h007E);
    bus_read(ADDR_DATA, rd);
    check("coinc_read", rd, 16'h007E);
    chk_reg("coinc_cleared", ADDR_ST, 16'h0000);

    // Reset in the middle of a TX frame
    bus_write(ADDR_DATA, 16'h0000);
    adv(3 * CLKS);
    check("midtx_low", {15'd0, uart_tx_o}, 16'h0000);
    sys_rst_i = 1'b1;
    adv(1);
    check("midtx_rst_line", {15'd0, uart_tx_o}, 16'h0001);
    chk_reg("midtx_rst_status", ADDR_ST, 16'h0000);
    sys_rst_i = 1'b0;
    adv(CLKS);
    check("midtx_stays_idle", {15'd0, uart_tx_o}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/j1_uart_io.md
Name: j1_uart_io

Overview:
- Memory-mapped UART peripheral that responds on the j1 CPU I/O bus. It decodes io_rd/io_wr/io_addr, accepts TX bytes from io_dout and returns RX data and status on io_din.
- It sits beside the j1 core in the top level. Its io_din is ORed/muxed with other peripherals using sel_o.
- Frame format: 8N1, LSB first, idle-high line.

Parameters:
- BASE_ADDR, 16'h5000, byte address of DATA register. STATUS is at BASE_ADDR+2. Bits [15:14] must be non-zero, so the CPU treats the access as I/O.
- CLKS_PER_BIT, 434, sys_clk_i cycles per bit (50 MHz / 115200). Must be ≥ 4.

Ports:
- sys_clk_i  in  1  system clock
- sys_rst_i  in  1  reset, synchronous, active-high
- io_rd  in  1  CPU I/O read strobe (combinational from CPU, valid for one cycle)
- io_wr  in  1  CPU I/O write strobe
- io_addr  in  16  byte address (CPU T register)
- io_dout  in  16  write data (CPU N register)
- io_din  out  16  read data to CPU
- sel_o  out  1  io_addr hits DATA or STATUS
- uart_tx_o  out  1  serial output
- uart_rx_i  in  1  serial input, asynchronous

Behaviour:
- Clocking/reset: one clock, sys_clk_i. Reset is synchronous, active-high (sys_rst_i). Reset values:
  - uart_tx_o=1
  - tx_busy=0, rx_valid=0, rx_overrun=0, rx_frame_err=0, rx_data=0
  - both FSMs IDLE, synchronizer flops=1
- Address decode: full 16-bit compare. DATA hit when io_addr==BASE_ADDR; STATUS hit when io_addr==BASE_ADDR+2. sel_o = either hit (combinational).
- Read path: io_din is purely combinational from registered state, because the CPU consumes it in the same cycle as io_rd.
  - DATA reads {8'h00, rx_data}.
  - STATUS reads {12'h000, rx_frame_err, rx_overrun, rx_valid, tx_busy} (bits 3..0).
  - No hit: 16'h0000.
- Read side effect: at the clock edge where io_rd & DATA hit, rx_valid clears to 0. A STATUS read has no side effect.
- Write DATA: io_wr & DATA hit & !tx_busy loads io_dout[7:0] into the TX shifter and sets tx_busy at that edge. A write while tx_busy=1 is dropped silently.
- Write STATUS: io_dout bit2=1 clears rx_overrun; bit3=1 clears rx_frame_err. Other bits are ignored.
- TX FSM, states IDLE→START→DATA(8 bits)→STOP→IDLE:
  - Each state/bit lasts exactly CLKS_PER_BIT cycles.
  - uart_tx_o is a registered output. It falls on the cycle after the accepting edge.
  - tx_busy drops at the end of STOP, so a frame is 10*CLKS_PER_BIT cycles.
  - A new write is accepted in the same cycle tx_busy reads 0.
- RX path: uart_rx_i passes through a 2-flop synchronizer. RX FSM states IDLE→START→DATA→STOP:
  - IDLE leaves on a synchronized low level.
  - START samples at CLKS_PER_BIT/2. If the line is high, the start is false: return to IDLE with no status change.
  - DATA samples 8 bits every CLKS_PER_BIT from mid-bit.
  - STOP samples once, mid-bit.
    - Stop=1: byte complete. If rx_valid=0, load rx_data and set rx_valid. If rx_valid=1, keep the old rx_data and set rx_overrun (sticky).
    - Stop=0: set rx_frame_err (sticky) and discard the byte.
  - After the STOP sample, wait for line high before IDLE.
- Simultaneous events:
  - DATA read-clear coinciding with byte completion: the new byte wins. rx_data is loaded, rx_valid stays 1, and no overrun is flagged.
  - Status write-clear coinciding with a new overrun/frame error: the set wins.
- Reset mid-frame aborts both FSMs immediately. uart_tx_o returns high on the next cycle.
- Counters: the bit-timer width is $clog2(CLKS_PER_BIT). Bit index is 3 bits, no wrap beyond 7.

Decomposition:
- Shared package j1_io_pkg holds:
  - register offsets (OFS_DATA=0, OFS_STATUS=2)
  - status bit positions (ST_TX_BUSY=0, ST_RX_VALID=1, ST_RX_OVERRUN=2, ST_RX_FRERR=3)
  - TX/RX state enums
- One natural sub-module: j1_uart_bit_timer, a down-counter with load/half-load and tick output, instantiated once for TX and once for RX.
- Bus decode and status registers stay in the top.

Test Plan:
- Reset, then read STATUS (io_rd, io_addr=16'h5002) → io_din=16'h0000, sel_o=1, uart_tx_o=1. Read at 16'h4000 → io_din=0, sel_o=0.
- Write 16'h00A5 to 16'h5000 → tx_busy=1 next cycle. uart_tx_o shows start, 1,0,1,0,0,1,0,1, stop, each exactly 434 cycles. tx_busy=0 after 4340 cycles. A second write during the frame is dropped and does not appear on the line.
- Drive RX frame 8'h3C → after the stop sample, STATUS=16'h0002. DATA read returns 16'h003C, then STATUS=16'h0000.
- Send 8'h11 then 8'h22 with no read → rx_data=16'h0011, STATUS=16'h0006. Write 16'h0004 to STATUS → STATUS=16'h0002.
- RX frame with stop bit 0 → STATUS bit3=1, rx_valid unchanged. A 100-cycle low glitch (< half bit) → no status change.
- DATA read on the exact cycle a new byte 8'h7E completes → rx_valid stays 1, DATA=16'h007E, overrun=0. Assert sys_rst_i mid-TX → uart_tx_o=1 next cycle, tx_busy=0.
